// File: rtl/uart_fifo_controller_if.sv
// Peripheral bus bundle for the UART: byte address, 32-bit data, write/read strobes.
interface uart_fifo_controller_if;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        we;
  logic        re;

  modport master (output addr, wdata, we, re, input rdata);
  modport slave  (input addr, wdata, we, re, output rdata);
endinterface

// File: rtl/uart_fifo_controller.sv
// Memory-mapped UART: TX/RX FIFOs, runtime baud divisor, optional parity, 1/2 stop bits,
// oversampled RX with mid-bit sampling, start-bit glitch rejection and a wake pulse.
module uart_fifo_controller #(
  parameter int DEFAULT_DIV = 868,
  parameter int FIFO_DEPTH  = 8,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_fifo_controller_if.slave  bus,
  input  logic                   uart_rx,
  output logic                   uart_tx,
  output logic                   wake
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TK_HALF = TW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  // Register decode and configuration
  logic        wr_tx, wr_status, wr_ctrl;
  logic [19:0] ctrl_q;
  logic [15:0] baud_div;
  logic        par_en, par_odd, two_stop, wake_en;
  logic        unused_wdata;

  assign wr_tx     = bus.we && (bus.addr == 4'h0);
  assign wr_status = bus.we && (bus.addr == 4'h8);
  assign wr_ctrl   = bus.we && (bus.addr == 4'hC);
  assign unused_wdata = ^bus.wdata[31:20];

  assign baud_div = ctrl_q[15:0];
  assign par_en   = (ctrl_q[17:16] == 2'b01) || (ctrl_q[17:16] == 2'b10);
  assign par_odd  = (ctrl_q[17:16] == 2'b10);
  assign two_stop = ctrl_q[18];
  assign wake_en  = ctrl_q[19];

  always_ff @(posedge clk) begin
    if (rst)          ctrl_q <= {1'b1, 1'b0, 2'b00, 16'(DEFAULT_DIV)};
    else if (wr_ctrl) ctrl_q <= bus.wdata[19:0];
  end

  // Oversample tick generator; a divisor of 0 behaves as 1
  logic [15:0] div_cnt_q, div_cnt_d, div_m1;
  logic        tick;

  assign div_m1 = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
  assign tick   = (div_cnt_q == div_m1);

  always_comb begin
    div_cnt_d = div_cnt_q + 16'd1;
    if (wr_ctrl || tick) div_cnt_d = 16'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) div_cnt_q <= 16'd0;
    else     div_cnt_q <= div_cnt_d;
  end

  // TX FIFO
  logic [7:0]    txf_mem [FIFO_DEPTH];
  logic [PW-1:0] txf_wp_q, txf_rp_q;
  logic [CW-1:0] txf_cnt_q;
  logic          txf_full, txf_empty, txf_push, txf_pop, tx_ovf_set;
  logic [7:0]    txf_rd;

  assign txf_full   = (txf_cnt_q == CW'(FIFO_DEPTH));
  assign txf_empty  = (txf_cnt_q == '0);
  assign txf_push   = wr_tx && !txf_full;
  assign tx_ovf_set = wr_tx && txf_full;
  assign txf_rd     = txf_mem[txf_rp_q];

  always_ff @(posedge clk) begin
    if (txf_push) txf_mem[txf_wp_q] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txf_wp_q  <= '0;
      txf_rp_q  <= '0;
      txf_cnt_q <= '0;
    end else begin
      if (txf_push) txf_wp_q <= txf_wp_q + PW'(1);
      if (txf_pop)  txf_rp_q <= txf_rp_q + PW'(1);
      txf_cnt_q <= txf_cnt_q + CW'(txf_push) - CW'(txf_pop);
    end
  end

  // TX FSM
  state_e        tx_state_q, tx_state_d;
  logic [TW-1:0] tx_tk_q, tx_tk_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic          tx_stop2_q, tx_stop2_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_q, tx_d;
  logic          tx_busy;

  assign tx_busy = !txf_empty || (tx_state_q != S_IDLE);
  assign uart_tx = tx_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tk_d    = tx_tk_q;
    tx_bit_d   = tx_bit_q;
    tx_stop2_d = tx_stop2_q;
    tx_sh_d    = tx_sh_q;
    tx_d       = tx_q;
    txf_pop    = 1'b0;
    if (tick) begin
      case (tx_state_q)
        S_IDLE: begin
          if (!txf_empty) begin
            txf_pop    = 1'b1;
            tx_sh_d    = txf_rd;
            tx_d       = 1'b0;
            tx_tk_d    = '0;
            tx_state_d = S_START;
          end
        end
        default: begin
          if (tx_tk_q != TK_LAST) begin
            tx_tk_d = tx_tk_q + TW'(1);
          end else begin
            tx_tk_d = '0;
            case (tx_state_q)
              S_START: begin
                tx_state_d = S_DATA;
                tx_bit_d   = 3'd0;
                tx_d       = tx_sh_q[0];
              end
              S_DATA: begin
                if (tx_bit_q == 3'd7) begin
                  if (par_en) begin
                    tx_state_d = S_PARITY;
                    tx_d       = par_odd ? ~^tx_sh_q : ^tx_sh_q;
                  end else begin
                    tx_state_d = S_STOP;
                    tx_stop2_d = 1'b0;
                    tx_d       = 1'b1;
                  end
                end else begin
                  tx_bit_d = tx_bit_q + 3'd1;
                  tx_d     = tx_sh_q[tx_bit_q + 3'd1];
                end
              end
              S_PARITY: begin
                tx_state_d = S_STOP;
                tx_stop2_d = 1'b0;
                tx_d       = 1'b1;
              end
              S_STOP: begin
                if (two_stop && !tx_stop2_q) begin
                  tx_stop2_d = 1'b1;
                end else if (!txf_empty) begin
                  // back-to-back frame: no idle gap after the stop bit
                  txf_pop    = 1'b1;
                  tx_sh_d    = txf_rd;
                  tx_d       = 1'b0;
                  tx_state_d = S_START;
                end else begin
                  tx_state_d = S_IDLE;
                  tx_d       = 1'b1;
                end
              end
              default: begin
                tx_state_d = S_IDLE;
                tx_d       = 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_tk_q    <= '0;
      tx_bit_q   <= 3'd0;
      tx_stop2_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tk_q    <= tx_tk_d;
      tx_bit_q   <= tx_bit_d;
      tx_stop2_q <= tx_stop2_d;
      tx_q       <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    tx_sh_q <= tx_sh_d;
  end

  // RX synchronizer and FSM
  logic          rx_meta_q, rx_s_q;
  state_e        rx_state_q, rx_state_d;
  logic [TW-1:0] rx_tk_q, rx_tk_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_par_q, rx_par_d;
  logic          rx_done, wake_d, wake_q;
  logic          rx_ferr, rx_perr;

  assign rx_ferr = !rx_s_q;
  assign rx_perr = par_en && (rx_par_q != (par_odd ? ~^rx_sh_q : ^rx_sh_q));
  assign wake    = wake_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tk_d    = rx_tk_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_par_d   = rx_par_q;
    rx_done    = 1'b0;
    wake_d     = 1'b0;
    if (tick) begin
      case (rx_state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            rx_state_d = S_START;
            rx_tk_d    = '0;
          end
        end
        S_START: begin
          if (rx_tk_q == TK_HALF) begin
            rx_tk_d = '0;
            if (!rx_s_q) begin
              rx_state_d = S_DATA;
              rx_bit_d   = 3'd0;
              wake_d     = wake_en;
            end else begin
              rx_state_d = S_IDLE;
            end
          end else begin
            rx_tk_d = rx_tk_q + TW'(1);
          end
        end
        default: begin
          if (rx_tk_q != TK_LAST) begin
            rx_tk_d = rx_tk_q + TW'(1);
          end else begin
            rx_tk_d = '0;
            case (rx_state_q)
              S_DATA: begin
                rx_sh_d = {rx_s_q, rx_sh_q[7:1]};
                if (rx_bit_q == 3'd7) rx_state_d = par_en ? S_PARITY : S_STOP;
                else                  rx_bit_d   = rx_bit_q + 3'd1;
              end
              S_PARITY: begin
                rx_par_d   = rx_s_q;
                rx_state_d = S_STOP;
              end
              default: begin
                rx_done    = 1'b1;
                rx_state_d = S_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_tk_q    <= '0;
      rx_bit_q   <= 3'd0;
      wake_q     <= 1'b0;
    end else begin
      rx_meta_q  <= uart_rx;
      rx_s_q     <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_tk_q    <= rx_tk_d;
      rx_bit_q   <= rx_bit_d;
      wake_q     <= wake_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_sh_q  <= rx_sh_d;
    rx_par_q <= rx_par_d;
  end

  // RX FIFO: entries are {ferr, perr, data}
  logic [9:0]    rxf_mem [FIFO_DEPTH];
  logic [PW-1:0] rxf_wp_q, rxf_rp_q;
  logic [CW-1:0] rxf_cnt_q;
  logic          rxf_full, rxf_empty, rxf_push, rxf_pop, rx_ovr_set;
  logic [9:0]    rxf_rd;

  assign rxf_full   = (rxf_cnt_q == CW'(FIFO_DEPTH));
  assign rxf_empty  = (rxf_cnt_q == '0);
  assign rxf_push   = rx_done && !rxf_full;
  assign rx_ovr_set = rx_done && rxf_full;
  assign rxf_pop    = bus.re && (bus.addr == 4'h4) && !rxf_empty;
  assign rxf_rd     = rxf_mem[rxf_rp_q];

  always_ff @(posedge clk) begin
    if (rxf_push) rxf_mem[rxf_wp_q] <= {rx_ferr, rx_perr, rx_sh_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxf_wp_q  <= '0;
      rxf_rp_q  <= '0;
      rxf_cnt_q <= '0;
    end else begin
      if (rxf_push) rxf_wp_q <= rxf_wp_q + PW'(1);
      if (rxf_pop)  rxf_rp_q <= rxf_rp_q + PW'(1);
      rxf_cnt_q <= rxf_cnt_q + CW'(rxf_push) - CW'(rxf_pop);
    end
  end

  // Sticky flags (set beats same-cycle clear) and registered read port
  logic        tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d;
  logic [31:0] rdata_q, rd_val;

  assign tx_ovf_d  = (tx_ovf_q && !(wr_status && bus.wdata[5])) || tx_ovf_set;
  assign rx_ovr_d  = (rx_ovr_q && !(wr_status && bus.wdata[4])) || rx_ovr_set;
  assign bus.rdata = rdata_q;

  always_comb begin
    rd_val = 32'd0;
    case (bus.addr)
      4'h4:    rd_val = rxf_empty ? 32'd0 : {22'd0, rxf_rd};
      4'h8:    rd_val = {26'd0, tx_ovf_q, rx_ovr_q, rxf_full, txf_full, !rxf_empty, tx_busy};
      4'hC:    rd_val = {12'd0, ctrl_q};
      default: rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf_q <= 1'b0;
      rx_ovr_q <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_ovr_q <= rx_ovr_d;
      if (bus.re) rdata_q <= rd_val;
    end
  end

endmodule

// File: tb/tb_uart_fifo_controller.sv
// Directed and randomized bench for uart_fifo_controller with a bit-level frame model.
module tb_uart_fifo_controller;
  localparam int OS     = 16;
  localparam int DEPTH  = 8;
  localparam int DIV    = 4;
  localparam int BITCLK = DIV * OS;

  logic clk = 1'b0;
  logic rst;
  logic rx_drv, loop_en;
  logic uart_tx, wake;
  wire  rx_line = loop_en ? uart_tx : rx_drv;

  int checks = 0;
  int errors = 0;
  int wake_cnt = 0;

  always #5 clk = ~clk;

  uart_fifo_controller_if bus();

  uart_fifo_controller #(.DEFAULT_DIV(868), .FIFO_DEPTH(DEPTH), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .uart_rx(rx_line), .uart_tx(uart_tx), .wake(wake)
  );

  always @(negedge clk) if (wake) wake_cnt <= wake_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.addr = a; bus.wdata = d; bus.we = 1'b1;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.addr = a; bus.re = 1'b1;
    @(negedge clk);
    bus.re = 1'b0;
    d = bus.rdata;
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  // Parity rule: mode 01 even (bit makes total ones even), 10 odd, otherwise none
  function automatic logic par_bit(input logic [7:0] b, input logic [1:0] mode);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return (mode == 2'b01) ? logic'(ones % 2) : logic'((ones + 1) % 2);
  endfunction

  function automatic logic [31:0] rx_word(input logic [7:0] b, input logic [1:0] mode,
                                          input logic par_sent, input logic stop_sent);
    logic has_par = (mode == 2'b01) || (mode == 2'b10);
    logic perr    = has_par && (par_sent != par_bit(b, mode));
    return {22'd0, ~stop_sent, perr, b};
  endfunction

  task automatic wait_tx_fall(input int limit, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic expect_tx_frame(input logic [7:0] b, input logic [1:0] mode, input logic ts,
                                 input int limit, input string tag);
    logic bits[$];
    logic ok;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (mode == 2'b01 || mode == 2'b10) bits.push_back(par_bit(b, mode));
    bits.push_back(1'b1);
    if (ts) bits.push_back(1'b1);
    wait_tx_fall(limit, ok);
    check({tag, "_start_seen"}, {31'd0, ok}, 32'd1);
    repeat (BITCLK / 2) @(negedge clk);
    foreach (bits[i]) begin
      if (i > 0) repeat (BITCLK) @(negedge clk);
      check($sformatf("%s_bit%0d", tag, i), {31'd0, uart_tx}, {31'd0, bits[i]});
    end
  endtask

  // Drives one frame on the RX line; a low stop bit is released early so it cannot look like a new start
  task automatic send_frame(input logic [7:0] b, input logic has_par, input logic par, input logic stop);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (BITCLK) @(negedge clk);
    end
    if (has_par) begin
      rx_drv = par;
      repeat (BITCLK) @(negedge clk);
    end
    rx_drv = stop;
    repeat (48) @(negedge clk);
    rx_drv = 1'b1;
    repeat (BITCLK) @(negedge clk);
  endtask

  initial begin
    logic [7:0]  exp_q[$];
    logic [7:0]  b;
    logic [31:0] d;
    logic [1:0]  mode;
    logic        ts, ok, ovr;
    int          w0;

    bus.addr = 4'h0; bus.wdata = 32'd0; bus.we = 1'b0; bus.re = 1'b0;
    rx_drv = 1'b1; loop_en = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_wake", {31'd0, wake}, 32'd0);
    read_check("rst_status", 4'h8, 32'h0000_0000);
    read_check("rst_ctrl", 4'hC, 32'h0008_0364);

    // Single TX frame, bit-accurate, then busy falls after stop
    bus_write(4'hC, 32'h0000_0004);
    bus_write(4'h0, 32'h0000_0055);
    expect_tx_frame(8'h55, 2'b00, 1'b0, 100, "tx55");
    read_check("tx55_busy_in_stop", 4'h8, 32'h0000_0001);
    repeat (BITCLK) @(negedge clk);
    read_check("tx55_idle", 4'h8, 32'h0000_0000);

    // Loopback of three back-to-back frames
    bus_write(4'hC, 32'h0008_0004);
    loop_en = 1'b1;
    w0 = wake_cnt;
    bus_write(4'h0, 32'h0000_00A5);
    bus_write(4'h0, 32'h0000_003C);
    bus_write(4'h0, 32'h0000_000F);
    wait_tx_fall(100, ok);
    check("loop_start_seen", {31'd0, ok}, 32'd1);
    repeat (3 * 10 * BITCLK + 16) @(negedge clk);
    read_check("loop_contiguous_status", 4'h8, 32'h0000_0002);
    read_check("loop_rx0", 4'h4, 32'h0000_00A5);
    read_check("loop_rx1", 4'h4, 32'h0000_003C);
    read_check("loop_rx2", 4'h4, 32'h0000_000F);
    check("loop_wake_pulses", 32'(wake_cnt - w0), 32'd3);
    loop_en = 1'b0;

    // Even parity, driven frames with error tags
    bus_write(4'hC, 32'h0009_0004);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    read_check("par_perr", 4'h4, rx_word(8'h07, 2'b01, 1'b0, 1'b1));
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    read_check("par_ferr", 4'h4, rx_word(8'h07, 2'b01, 1'b1, 1'b0));

    // RX overrun: FIFO_DEPTH+1 random frames with no reads
    bus_write(4'hC, 32'h0008_0004);
    exp_q.delete();
    ovr = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b0, 1'b0, 1'b1);
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else ovr = 1'b1;
    end
    read_check("ovr_status", 4'h8,
               {26'd0, 1'b0, ovr, exp_q.size() == DEPTH, 1'b0, exp_q.size() != 0, 1'b0});
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      read_check("ovr_data", 4'h4, {24'd0, b});
    end
    read_check("ovr_sticky", 4'h8, {27'd0, ovr, 4'd0});
    bus_write(4'h8, 32'h0000_0010);
    read_check("ovr_cleared", 4'h8, 32'h0000_0000);

    // Start-bit glitch of 12 clocks is rejected
    w0 = wake_cnt;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (12) @(negedge clk);
    rx_drv = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_no_wake", 32'(wake_cnt - w0), 32'd0);
    read_check("glitch_status", 4'h8, 32'h0000_0000);
    read_check("empty_rxdata", 4'h4, 32'h0000_0000);

    // Randomized loopback with random parity and stop configuration
    mode = 2'($urandom_range(0, 3));
    ts   = 1'($urandom_range(0, 1));
    bus_write(4'hC, {12'd0, 1'b1, ts, mode, 16'(DIV)});
    loop_en = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      bus_write(4'h0, {24'd0, b});
    end
    expect_tx_frame(exp_q[0], mode, ts, 100, "rnd_tx0");
    repeat (4 * 12 * BITCLK) @(negedge clk);
    read_check("rnd_status", 4'h8, 32'h0000_0002);
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      read_check("rnd_rx", 4'h4, rx_word(b, mode, par_bit(b, mode), 1'b1));
    end
    loop_en = 1'b0;

    // TX overflow, W1C, and reset in the middle of a frame
    bus_write(4'hC, 32'h0008_03E8);
    for (int i = 0; i < DEPTH + 1; i++) bus_write(4'h0, 32'(i));
    read_check("txovf_status", 4'h8, 32'h0000_0025);
    bus_write(4'h8, 32'h0000_0020);
    read_check("txovf_cleared", 4'h8, 32'h0000_0005);
    wait_tx_fall(1200, ok);
    check("slow_start_seen", {31'd0, ok}, 32'd1);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_tx_high", {31'd0, uart_tx}, 32'd1);
    read_check("midreset_status", 4'h8, 32'h0000_0000);
    read_check("midreset_ctrl", 4'hC, 32'h0008_0364);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
